// File: rtl/cs2fifoc.sv
// cs2fifoc: latches nine command fields and streams one framed, checksummed command into the TX FIFO.
module cs2fifoc #(
  parameter int MIN_LEN = 12,
  parameter int MAX_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [11:0] data_len,
  input  logic [7:0]  kind_dev,
  input  logic [7:0]  info_sr,
  input  logic [7:0]  cmd_filt,
  input  logic [7:0]  cmd_mix0,
  input  logic [7:0]  cmd_reg4,
  input  logic [7:0]  cmd_reg5,
  input  logic [7:0]  cmd_reg6,
  input  logic [7:0]  cmd_reg7,
  input  logic [7:0]  cmd_mix1,
  input  logic        fifoc_full,
  output logic        fifoc_txen,
  output logic [7:0]  fifoc_txd,
  output logic [7:0]  so
);
  typedef enum logic [7:0] {IDLE = 8'h00, LOAD = 8'h01, SEND = 8'h03, LAST = 8'h0F} state_t;
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  state_t      state_q;
  logic [11:0] idx_q, len_q, idx_m2;
  logic [7:0]  acc_q, byte_d;
  logic [7:0]  f_q [9];
  logic        fd_q, err_q, wr, legal, add;
  always_comb begin
    idx_m2 = idx_q - 12'd2;
    byte_d = idx_q == 12'd0 ? 8'h55 :
             idx_q == 12'd1 ? 8'hAA :
             idx_q == len_q - 12'd1 ? acc_q :
             idx_q <= 12'd10 ? f_q[idx_m2[3:0]] : 8'h00;
    wr     = state_q == SEND && !fifoc_full;
    add    = idx_q >= 12'd2 && idx_q <= len_q - 12'd2;
    legal  = data_len >= MIN_L && data_len <= MAX_L;
  end
  assign fifoc_txen = wr;
  assign fifoc_txd  = state_q == SEND ? byte_d : 8'h00;
  assign fd  = fd_q;
  assign err = err_q;
  assign so  = state_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 9; i++) f_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (fs) state_q <= LOAD;
        LOAD: begin
          f_q[0]  <= kind_dev;
          f_q[1]  <= info_sr;
          f_q[2]  <= cmd_filt;
          f_q[3]  <= cmd_mix0;
          f_q[4]  <= cmd_reg4;
          f_q[5]  <= cmd_reg5;
          f_q[6]  <= cmd_reg6;
          f_q[7]  <= cmd_reg7;
          f_q[8]  <= cmd_mix1;
          len_q   <= data_len;
          acc_q   <= '0;
          idx_q   <= '0;
          err_q   <= !legal;
          fd_q    <= !legal;
          state_q <= legal ? SEND : LAST;
        end
        SEND: if (wr) begin
          idx_q <= idx_q + 12'd1;
          if (add) acc_q <= acc_q + byte_d;
          if (idx_q == len_q - 12'd1) begin
            state_q <= LAST;
            fd_q    <= 1'b1;
          end
        end
        LAST: if (!fs) begin
          state_q <= IDLE;
          fd_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          fd_q    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cs2fifoc.sv
// tb_cs2fifoc: directed frames with a byte scoreboard checked by an independent FIFO-write monitor.
module tb_cs2fifoc;
  logic        clk = 0, rst = 1, fs = 0, fifoc_full = 0;
  logic [11:0] data_len = 0;
  logic [7:0]  f [9];
  logic        fd, err, fifoc_txen;
  logic [7:0]  fifoc_txd, so;
  logic [7:0]  exp_q [$];
  int          total = 0, bad = 0;

  cs2fifoc dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err), .data_len(data_len),
    .kind_dev(f[0]), .info_sr(f[1]), .cmd_filt(f[2]), .cmd_mix0(f[3]), .cmd_reg4(f[4]),
    .cmd_reg5(f[5]), .cmd_reg6(f[6]), .cmd_reg7(f[7]), .cmd_mix1(f[8]),
    .fifoc_full(fifoc_full), .fifoc_txen(fifoc_txen), .fifoc_txd(fifoc_txd), .so(so)
  );

  always #5 clk = ~clk;

  // Every presented write must match the head of the expected byte stream.
  always @(negedge clk) if (fifoc_txen) begin
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_write got=%02h expected=none", fifoc_txd);
    end else begin
      automatic logic [7:0] e = exp_q.pop_front();
      if (fifoc_txd !== e) begin
        bad++;
        $display("FAIL txd got=%02h expected=%02h", fifoc_txd, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // stall: FIFO full 3 cycles at idx 5 and 1 cycle at idx 11; drop_k/rst_k: cycle after fs edge to drop fs / pulse rst
  task automatic frame(input int len, input bit ff, input logic [7:0] cks, input bit stall,
                       input int drop_k, input int hold, input int rst_k);
    automatic bit legal = len >= 12 && len <= 32;
    automatic int e_fd = legal ? len + 2 + (stall ? 4 : 0) : 2;
    data_len = 12'(len);
    for (int i = 0; i < 9; i++) f[i] = ff ? 8'hFF : 8'(i + 1);
    if (legal) begin
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      for (int i = 0; i < 9; i++) exp_q.push_back(f[i]);
      for (int i = 11; i < len - 1; i++) exp_q.push_back(8'h00);
      exp_q.push_back(cks);
    end
    @(posedge clk) #1 fs = 1;
    for (int k = 1; k <= e_fd; k++) begin
      @(posedge clk) #1;
      fifoc_full = stall && (k inside {[7:9], 16});
      if (k == 2) begin
        data_len = 12'd99;
        for (int i = 0; i < 9; i++) f[i] = 8'hEE;
      end
      if (k == drop_k) fs = 0;
      if (k == rst_k) begin
        rst = 1;
        #1;
        chk("rst_so", 12'(so), 12'h00);
        chk("rst_txen", 12'(fifoc_txen), 12'h0);
        chk("rst_err", 12'(err), 12'h0);
        chk("rst_fd", 12'(fd), 12'h0);
        #1 rst = 0;
        fs = 0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
      if (k == e_fd - 1) chk("fd_early", 12'(fd), 12'h0);
      if (k == e_fd) chk("fd_rise", 12'(fd), 12'h1);
    end
    fifoc_full = 0;
    chk("err", 12'(err), 12'(!legal));
    chk("bytes_left", 12'(exp_q.size()), 12'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("fd_hold", 12'(fd), 12'h1);
      chk("so_hold", 12'(so), 12'h0F);
    end
    @(posedge clk) #1 fs = 0;
    @(posedge clk) #1;
    @(negedge clk);
    chk("so_idle", 12'(so), 12'h00);
    chk("fd_low", 12'(fd), 12'h0);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) f[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_so", 12'(so), 12'h00);
    chk("reset_fd", 12'(fd), 12'h0);
    chk("reset_err", 12'(err), 12'h0);
    chk("reset_txen", 12'(fifoc_txen), 12'h0);
    chk("reset_txd", 12'(fifoc_txd), 12'h00);
    rst = 0;
    frame(12, 0, 8'h2D, 0, 0, 0, 0);
    frame(16, 0, 8'h2D, 0, 0, 0, 0);
    frame(12, 1, 8'hF7, 0, 0, 0, 0);
    frame(12, 0, 8'h2D, 1, 0, 0, 0);
    frame(11, 0, 8'h00, 0, 0, 0, 0);
    frame(33, 0, 8'h00, 0, 0, 0, 0);
    frame(32, 1, 8'hF7, 0, 0, 0, 0);
    frame(12, 0, 8'h2D, 0, 6, 0, 0);
    frame(12, 0, 8'h2D, 0, 0, 5, 0);
    frame(33, 0, 8'h00, 0, 0, 0, 0);
    frame(12, 0, 8'h2D, 0, 0, 0, 8);
    repeat (2) @(posedge clk);
    frame(12, 0, 8'h2D, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
